// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared op/state encodings and sizes for the iterative mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
// ============================================================================
// Module   : muldiv_sign_fix
// Brief    : Combinational magnitude extraction at issue and sign correction
//            of the unsigned core result at writeback (MULDIV_SIGNED_EN only).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    output logic [WIDTH-1:0]     mag1,
    output logic [WIDTH-1:0]     mag2,
    output logic                 neg1,
    output logic                 neg2,
    input  logic                 is_div,
    input  logic                 div_zero,
    input  logic                 res_neg1,
    input  logic                 res_neg2,
    input  logic [2*WIDTH-1:0]   raw,
    output logic [2*WIDTH-1:0]   fixed
);

    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    always_comb begin
        neg1 = sgn & op1[WIDTH-1];
        neg2 = sgn & op2[WIDTH-1];
        mag1 = neg1 ? -op1 : op1;
        mag2 = neg2 ? -op2 : op2;
    end

    // A zero divisor keeps the all-ones quotient; the remainder already
    // reproduces the signed dividend once its sign is restored.
    always_comb begin
        w_quo = raw[WIDTH-1:0];
        w_rem = raw[2*WIDTH-1:WIDTH];
        fixed = raw;
        if (is_div) begin
            if ((res_neg1 ^ res_neg2) && !div_zero) begin
                w_quo = -raw[WIDTH-1:0];
            end
            if (res_neg1) begin
                w_rem = -raw[2*WIDTH-1:WIDTH];
            end
            fixed = {w_rem, w_quo};
        end else if (res_neg1 ^ res_neg2) begin
            fixed = -raw;
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative 32-cycle multiply/divide unit with HI/LO registers and
//            start/busy/done handshake. Signed ops enabled by MULDIV_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    input  logic             hi_wr,
    input  logic             lo_wr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH-1:0]   w_sub;
    logic               w_ge;
    logic               w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
    logic w_neg1;
    logic w_neg2;
    logic r_neg1;
    logic r_neg2;
    logic w_div_zero;

    assign w_div_zero = (r_a == '0);

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .sgn      (op[1]),
        .op1      (Op1),
        .op2      (Op2),
        .mag1     (w_mag1),
        .mag2     (w_mag2),
        .neg1     (w_neg1),
        .neg2     (w_neg2),
        .is_div   (r_is_div),
        .div_zero (w_div_zero),
        .res_neg1 (r_neg1),
        .res_neg2 (r_neg2),
        .raw      (w_acc_nxt),
        .fixed    (w_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg1 <= 1'b0;
            r_neg2 <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_neg1 <= w_neg1;
            r_neg2 <= w_neg2;
        end
    end
`else
    logic w_unused_op;

    assign w_unused_op = op[1];
    assign w_mag1      = Op1;
    assign w_mag2      = Op2;
    assign w_res       = w_acc_nxt;
`endif

    // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient};
    // Op2 always sits in r_a, which works for both since the product commutes.
    always_comb begin
        w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
        w_shl = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_ge  = (w_shl >= {1'b0, r_a});
        w_sub = w_shl[WIDTH-1:0] - r_a;
        if (r_is_div) begin
            w_acc_nxt = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                             : {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_acc_nxt = {w_add, r_acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_a      <= '0;
            r_acc    <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_is_div <= op[0];
                        r_a      <= w_mag2;
                        r_acc    <= {{WIDTH{1'b0}}, w_mag1};
                    end else begin
                        if (hi_wr) begin
                            hi <= Op1;
                        end
                        if (lo_wr) begin
                            lo <= Op1;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        hi <= w_res[2*WIDTH-1:WIDTH];
                        lo <= w_res[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench for muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] Op1   = '0;
    logic [31:0] Op2   = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .Op1   (Op1),
        .Op2   (Op2),
        .hi_wr (hi_wr),
        .lo_wr (lo_wr),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference: returns {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic   sgn;
        longint sa, sb;
        int     ia, ib, q, r;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = o[1];
`endif
        if (!o[0]) begin
            if (sgn) begin
                ia = $signed(a);
                ib = $signed(b);
                sa = ia;
                sb = ib;
                return 64'(sa * sb);
            end
            return {32'h0, a} * {32'h0, b};
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            ia = $signed(a);
            ib = $signed(b);
            q  = ia / ib;
            r  = ia % ib;
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1; op = o; Op1 = a; Op2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); Op1 = $urandom; Op2 = $urandom;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        #12;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL reset_hilo: got %h/%h expected 0/0", hi, lo);
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_flags: got busy=%b done=%b expected 0/0", busy, done);
        if (hi !== 32'h0 || lo !== 32'h0) errors++;
        if (busy !== 1'b0 || done !== 1'b0) errors++;
        @(negedge clk); rst = 1'b0;
        hi_wr = 1'b1; lo_wr = 1'b1; Op1 = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        hi_wr = 1'b0; lo_wr = 1'b0;
        checks++;
        if (hi !== 32'h5A5A_5A5A || lo !== 32'h5A5A_5A5A) begin
            errors++; $display("FAIL mthi_mtlo_both: got %h/%h expected 5a5a5a5a/5a5a5a5a", hi, lo);
        end
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; Op1 = 32'd7; Op2 = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_calc: got busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
        end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_discard: got %0d busy/done cycles expected 0", seen);
        end
    endtask

    task automatic test_multu();
        int lat;
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checks++; if (lat != 32) begin errors++; $display("FAIL multu_latency: got %0d expected 32", lat); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_busy: got %b expected 1", busy); end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL after_e33: got busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_divu();
        int lat;
        do_op(OP_DIVU, 32'd100, 32'd7, lat);
        checks++; if (lat != 32) begin errors++; $display("FAIL divu_latency: got %0d expected 32", lat); end
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            errors++; $display("FAIL divu_100_7: got lo=%0d hi=%0d expected 14/2", lo, hi);
        end
        do_op(OP_DIVU, 32'd5, 32'd0, lat);
        checks++;
        if (lat != 32 || lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
            errors++; $display("FAIL divu_by_zero: got lat=%0d lo=%h hi=%h expected 32/ffffffff/00000005", lat, lo, hi);
        end
    endtask

    task automatic test_ignored();
        int lat;
        @(posedge clk); @(negedge clk);
        hi_wr = 1'b1; Op1 = 32'h1111;
        @(posedge clk); #1;
        hi_wr = 1'b0;
        checks++; if (hi !== 32'h1111) begin errors++; $display("FAIL mthi_only: got %h expected 00001111", hi); end
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; Op1 = 32'd100; Op2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin start = 1'b1; hi_wr = 1'b1; lo_wr = 1'b1; op = OP_MULTU; Op1 = 32'hABCD; end
            if (k == 8) begin start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0; end
            if (k == 6) begin
                checks++;
                if (hi !== 32'h1111) begin errors++; $display("FAIL hold_in_calc: got %h expected 00001111", hi); end
            end
            if (done) begin lat = k; break; end
        end
        checks++;
        if (lat != 32 || lo !== 32'd14 || hi !== 32'd2) begin
            errors++; $display("FAIL ignore_in_calc: got lat=%0d lo=%0d hi=%0d expected 32/14/2", lat, lo, hi);
        end
        hi_wr = 1'b1; Op1 = 32'hABCD;
        @(posedge clk); #1;
        hi_wr = 1'b0;
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL ignore_in_done: got %h expected 00000002", hi); end
        @(negedge clk);
        start = 1'b1; hi_wr = 1'b1; op = OP_MULTU; Op1 = 32'hABCD; Op2 = 32'd1;
        @(posedge clk); #1;
        start = 1'b0; hi_wr = 1'b0;
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL start_priority: got %h expected 00000002", hi); end
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        checks++;
        if (lat != 32 || hi !== 32'h0 || lo !== 32'hABCD) begin
            errors++; $display("FAIL start_with_mthi: got lat=%0d hi=%h lo=%h expected 32/00000000/0000abcd", lat, hi, lo);
        end
        @(posedge clk); @(negedge clk);
        hi_wr = 1'b1; Op1 = 32'hABCD;
        @(posedge clk); #1;
        hi_wr = 1'b0;
        checks++; if (hi !== 32'hABCD) begin errors++; $display("FAIL mthi_abcd: got %h expected 0000abcd", hi); end
    endtask

    task automatic test_signed();
        int lat;
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat);
        checks++;
`ifdef MULDIV_SIGNED_EN
        if (lat != 32 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            errors++; $display("FAIL mult_m3x5: got lat=%0d hi=%h lo=%h expected 32/ffffffff/fffffff1", lat, hi, lo);
        end
`else
        if (lat != 32 || hi !== 32'h0000_0004 || lo !== 32'hFFFF_FFF1) begin
            errors++; $display("FAIL mult_m3x5: got lat=%0d hi=%h lo=%h expected 32/00000004/fffffff1", lat, hi, lo);
        end
`endif
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        checks++;
`ifdef MULDIV_SIGNED_EN
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_m7_2: got lo=%h hi=%h expected fffffffd/ffffffff", lo, hi);
        end
`else
        if (lo !== 32'h7FFF_FFFC || hi !== 32'h0000_0001) begin
            errors++; $display("FAIL div_m7_2: got lo=%h hi=%h expected 7ffffffc/00000001", lo, hi);
        end
`endif
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++;
`ifdef MULDIV_SIGNED_EN
        if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
            errors++; $display("FAIL div_min_m1: got lo=%h hi=%h expected 80000000/00000000", lo, hi);
        end
`else
        if (lo !== 32'h0 || hi !== 32'h8000_0000) begin
            errors++; $display("FAIL div_min_m1: got lo=%h hi=%h expected 00000000/80000000", lo, hi);
        end
`endif
        do_op(OP_DIV, 32'hFFFF_FFF7, 32'd0, lat);
        checks++;
        if (lat != 32 || lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF7) begin
            errors++; $display("FAIL div_by_zero_neg: got lat=%0d lo=%h hi=%h expected 32/ffffffff/fffffff7", lat, lo, hi);
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            exp = model(o, a, b);
            do_op(o, a, b, lat);
            checks++;
            if (lat != 32 || {hi, lo} !== exp) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h expected 32/%h/%h",
                         i, o, a, b, lat, hi, lo, exp[63:32], exp[31:0]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_multu();
        test_divu();
        test_ignored();
        test_signed();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
